// File: rtl/pipeline_arbiter_if.sv
// rtl/pipeline_arbiter_if.sv - buffer/pipeline handshake bundle for pipeline_arbiter
// slave is the arbiter side; master is the buffer array plus allocation pipeline.
interface pipeline_arbiter_if #(
  parameter int NUM_BUFFERS = 4,
  parameter int ID_W = $clog2(NUM_BUFFERS)
);
  logic [NUM_BUFFERS-1:0] req_pipeline;
  logic [NUM_BUFFERS-1:0] active;
  logic                   pipe_ready;
  logic                   pipe_resp_valid;
  logic [ID_W-1:0]        pipe_resp_id;
  logic                   pipe_resp_ok;
  logic [NUM_BUFFERS-1:0] reg_bank_req;
  logic                   pipe_valid;
  logic [ID_W-1:0]        pipe_id;
  logic [NUM_BUFFERS-1:0] pipeline_granted;
  logic [NUM_BUFFERS-1:0] pipeline_failed;
  logic [NUM_BUFFERS-1:0] reg_bank_granted;

  modport master (
    output req_pipeline, active, pipe_ready, pipe_resp_valid, pipe_resp_id, pipe_resp_ok,
           reg_bank_req,
    input  pipe_valid, pipe_id, pipeline_granted, pipeline_failed, reg_bank_granted
  );

  modport slave (
    input  req_pipeline, active, pipe_ready, pipe_resp_valid, pipe_resp_id, pipe_resp_ok,
           reg_bank_req,
    output pipe_valid, pipe_id, pipeline_granted, pipeline_failed, reg_bank_granted
  );
endinterface

// File: rtl/pipeline_arbiter.sv
// rtl/pipeline_arbiter.sv - round-robin arbiter for the shared allocation pipeline and register bank
// One outstanding pipeline transaction per buffer; failed allocations back off before retrying.
module pipeline_arbiter #(
  parameter int NUM_BUFFERS = 4,
  parameter int BACKOFF = 3,
  parameter int ID_W = $clog2(NUM_BUFFERS)
) (
  input logic               clk,
  input logic               n_rst,
  pipeline_arbiter_if.slave bus
);
  localparam int BO_W = (BACKOFF < 1) ? 1 : $clog2(BACKOFF + 1);
  localparam logic [BO_W-1:0] BO_LOAD = BO_W'(BACKOFF);
  localparam logic [NUM_BUFFERS-1:0] ONE = NUM_BUFFERS'(1);

  logic [ID_W-1:0]        r_rr_ptr;
  logic [NUM_BUFFERS-1:0] r_outstanding;
  logic [BO_W-1:0]        r_backoff [NUM_BUFFERS];
  logic [ID_W-1:0]        r_rb_ptr;
  logic                   r_rb_owner_valid;
  logic [ID_W-1:0]        r_rb_owner;
  logic                   r_pipe_valid;
  logic [ID_W-1:0]        r_pipe_id;
  logic [NUM_BUFFERS-1:0] r_granted;
  logic [NUM_BUFFERS-1:0] r_failed;
  logic [NUM_BUFFERS-1:0] r_rb_granted;

  logic [NUM_BUFFERS-1:0] w_elig;
  logic                   w_issue;
  logic [ID_W-1:0]        w_issue_id;
  logic                   w_rb_pick;
  logic [ID_W-1:0]        w_rb_id;
  logic                   w_resp_hit;
  logic                   w_resp_fail;

  function automatic logic [ID_W-1:0] f_next(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_BUFFERS - 1)) ? '0 : id + 1'b1;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_BUFFERS; i++) begin
      w_elig[i] = bus.req_pipeline[i] & ~bus.active[i] & ~r_outstanding[i] & (r_backoff[i] == '0);
    end
  end

  // Scan from the farthest candidate down so the one nearest the pointer is written last and wins.
  always_comb begin
    logic [ID_W-1:0] cand;
    w_issue    = 1'b0;
    w_issue_id = '0;
    w_rb_pick  = 1'b0;
    w_rb_id    = '0;
    cand       = '0;
    for (int k = NUM_BUFFERS - 1; k >= 0; k--) begin
      cand = ID_W'((int'(r_rr_ptr) + k) % NUM_BUFFERS);
      if (bus.pipe_ready && w_elig[cand]) begin
        w_issue    = 1'b1;
        w_issue_id = cand;
      end
      cand = ID_W'((int'(r_rb_ptr) + k) % NUM_BUFFERS);
      if (bus.reg_bank_req[cand]) begin
        w_rb_pick = 1'b1;
        w_rb_id   = cand;
      end
    end
  end

  // An issue targets a non-outstanding buffer and a hit targets an outstanding one, so they never collide.
  assign w_resp_hit  = bus.pipe_resp_valid && (int'(bus.pipe_resp_id) < NUM_BUFFERS) &&
                       r_outstanding[bus.pipe_resp_id];
  assign w_resp_fail = w_resp_hit && !bus.pipe_resp_ok;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_rr_ptr         <= '0;
      r_outstanding    <= '0;
      r_rb_ptr         <= '0;
      r_rb_owner_valid <= 1'b0;
      r_rb_owner       <= '0;
      r_pipe_valid     <= 1'b0;
      r_pipe_id        <= '0;
      r_granted        <= '0;
      r_failed         <= '0;
      r_rb_granted     <= '0;
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        r_backoff[i] <= '0;
      end
    end else begin
      r_pipe_valid <= w_issue;
      r_pipe_id    <= w_issue_id;
      r_granted    <= w_issue ? (ONE << w_issue_id) : '0;
      r_failed     <= w_resp_fail ? (ONE << bus.pipe_resp_id) : '0;
      if (w_issue) begin
        r_rr_ptr <= f_next(w_issue_id);
      end
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        if (w_issue && w_issue_id == ID_W'(i)) begin
          r_outstanding[i] <= 1'b1;
        end else if (w_resp_hit && bus.pipe_resp_id == ID_W'(i)) begin
          r_outstanding[i] <= 1'b0;
        end
        if (w_resp_fail && bus.pipe_resp_id == ID_W'(i)) begin
          r_backoff[i] <= BO_LOAD;
        end else if (r_backoff[i] != '0) begin
          r_backoff[i] <= r_backoff[i] - 1'b1;
        end
      end
      // The release cycle deliberately picks nobody, leaving a one-cycle gap between owners.
      if (r_rb_owner_valid) begin
        if (!bus.reg_bank_req[r_rb_owner]) begin
          r_rb_owner_valid <= 1'b0;
          r_rb_granted     <= '0;
        end
      end else if (w_rb_pick) begin
        r_rb_owner_valid <= 1'b1;
        r_rb_owner       <= w_rb_id;
        r_rb_granted     <= ONE << w_rb_id;
        r_rb_ptr         <= f_next(w_rb_id);
      end
    end
  end

  assign bus.pipe_valid       = r_pipe_valid;
  assign bus.pipe_id          = r_pipe_id;
  assign bus.pipeline_granted = r_granted;
  assign bus.pipeline_failed  = r_failed;
  assign bus.reg_bank_granted = r_rb_granted;
endmodule

// File: tb/tb_pipeline_arbiter.sv
// tb/tb_pipeline_arbiter.sv - self-checking bench for pipeline_arbiter against a cycle-count reference model
module tb_pipeline_arbiter;
  localparam int N = 4;
  localparam int BACKOFF = 3;
  localparam int ID_W = 2;

  logic clk = 1'b0;
  logic n_rst;
  always #5 clk = ~clk;

  pipeline_arbiter_if #(.NUM_BUFFERS(N), .ID_W(ID_W)) bus ();
  pipeline_arbiter #(.NUM_BUFFERS(N), .BACKOFF(BACKOFF), .ID_W(ID_W)) dut (
    .clk(clk), .n_rst(n_rst), .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: outstanding flags, the sample cycle at which each buffer may next be considered,
  // and pointers/owner held as plain integers.
  bit m_out [N];
  int m_ready [N];
  int m_rr, m_rb, m_owner;
  logic               e_valid;
  logic [ID_W-1:0]    e_id;
  logic [N-1:0]       e_grant, e_fail, e_rb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    int issue;
    int idx;
    if (!n_rst) begin
      for (int i = 0; i < N; i++) begin
        m_out[i] = 0;
        m_ready[i] = 0;
      end
      m_rr = 0; m_rb = 0; m_owner = -1;
      e_valid = 0; e_id = 0; e_grant = 0; e_fail = 0; e_rb = 0;
      return;
    end
    e_valid = 0; e_id = 0; e_grant = 0; e_fail = 0;
    issue = -1;
    if (bus.pipe_ready) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (bus.req_pipeline[idx] && !bus.active[idx] && !m_out[idx] && cyc >= m_ready[idx]) begin
          issue = idx;
          break;
        end
      end
    end
    if (bus.pipe_resp_valid && m_out[bus.pipe_resp_id]) begin
      m_out[bus.pipe_resp_id] = 0;
      if (!bus.pipe_resp_ok) begin
        e_fail[bus.pipe_resp_id] = 1'b1;
        m_ready[bus.pipe_resp_id] = cyc + 1 + BACKOFF;
      end
    end
    if (issue >= 0) begin
      m_out[issue] = 1;
      e_grant[issue] = 1'b1;
      e_valid = 1'b1;
      e_id = ID_W'(issue);
      m_rr = (issue + 1) % N;
    end
    if (m_owner >= 0) begin
      if (!bus.reg_bank_req[m_owner]) begin
        m_owner = -1;
        e_rb = 0;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        idx = (m_rb + k) % N;
        if (bus.reg_bank_req[idx]) begin
          m_owner = idx;
          m_rb = (idx + 1) % N;
          e_rb = 0;
          e_rb[idx] = 1'b1;
          break;
        end
      end
    end
  endtask

  task automatic compare();
    check("pipe_valid", 32'(bus.pipe_valid), 32'(e_valid));
    check("pipeline_granted", 32'(bus.pipeline_granted), 32'(e_grant));
    check("pipeline_failed", 32'(bus.pipeline_failed), 32'(e_fail));
    check("reg_bank_granted", 32'(bus.reg_bank_granted), 32'(e_rb));
    if (e_valid) check("pipe_id", 32'(bus.pipe_id), 32'(e_id));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare();
  endtask

  task automatic idle_inputs();
    bus.req_pipeline = '0; bus.active = '0; bus.pipe_ready = 1'b0;
    bus.pipe_resp_valid = 1'b0; bus.pipe_resp_id = '0; bus.pipe_resp_ok = 1'b0;
    bus.reg_bank_req = '0;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    idle_inputs();
    cycle();
    n_rst = 1'b1;
  endtask

  task automatic respond(input int id, input bit ok);
    bus.pipe_resp_valid = 1'b1;
    bus.pipe_resp_id = ID_W'(id);
    bus.pipe_resp_ok = ok;
    cycle();
    bus.pipe_resp_valid = 1'b0;
  endtask

  initial begin
    int rid;
    logic [N-1:0] exp_seq;
    n_rst = 1'b0;
    idle_inputs();
    cycle();
    cycle();
    check("reset_grant", 32'(bus.pipeline_granted), 32'h0);
    check("reset_rb", 32'(bus.reg_bank_granted), 32'h0);
    n_rst = 1'b1;

    // All four request: grants sweep 0,1,2,3 then stop.
    bus.req_pipeline = 4'b1111;
    bus.pipe_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      exp_seq = (k < 4) ? N'(1 << k) : '0;
      check("sweep_grant", 32'(bus.pipeline_granted), 32'(exp_seq));
    end
    bus.req_pipeline = '0;
    for (int i = 0; i < N; i++) respond(i, 1'b1);

    // Buffer 2 alone, ok response -> regrant two cycles later.
    bus.req_pipeline = 4'b0100;
    cycle();
    check("b2_grant", 32'(bus.pipeline_granted), 32'h4);
    cycle();
    check("b2_no_regrant", 32'(bus.pipeline_granted), 32'h0);
    respond(2, 1'b1);
    check("b2_t1", 32'(bus.pipeline_granted), 32'h0);
    cycle();
    check("b2_t2_regrant", 32'(bus.pipeline_granted), 32'h4);
    bus.req_pipeline = '0;
    respond(2, 1'b1);

    // Buffer 1 fails -> failed pulse at t+1, regrant at t+5.
    bus.req_pipeline = 4'b0010;
    cycle();
    check("b1_grant", 32'(bus.pipeline_granted), 32'h2);
    respond(1, 1'b0);
    check("b1_failed", 32'(bus.pipeline_failed), 32'h2);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check("b1_backoff", 32'(bus.pipeline_granted), 32'h0);
      check("b1_fail_pulse", 32'(bus.pipeline_failed), 32'h0);
    end
    cycle();
    check("b1_regrant", 32'(bus.pipeline_granted), 32'h2);
    bus.req_pipeline = '0;
    respond(1, 1'b1);

    // Active masks buffers 0 and 2 while pipe_ready toggles.
    bus.req_pipeline = 4'b1111;
    bus.active = 4'b0101;
    for (int k = 0; k < 16; k++) begin
      bus.pipe_ready = k[0] ? 1'b0 : 1'b1;
      bus.pipe_resp_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_out[i]) begin
          bus.pipe_resp_valid = 1'b1;
          bus.pipe_resp_id = ID_W'(i);
          bus.pipe_resp_ok = 1'b1;
          break;
        end
      end
      cycle();
      check("active_mask", 32'(bus.pipeline_granted & 4'b0101), 32'h0);
    end
    do_reset();

    // Register bank grant and hand-off gap.
    bus.reg_bank_req = 4'b0110;
    cycle();
    check("rb_first", 32'(bus.reg_bank_granted), 32'h2);
    cycle();
    check("rb_hold", 32'(bus.reg_bank_granted), 32'h2);
    bus.reg_bank_req = 4'b0100;
    cycle();
    check("rb_gap", 32'(bus.reg_bank_granted), 32'h0);
    cycle();
    check("rb_next", 32'(bus.reg_bank_granted), 32'h4);
    do_reset();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      n_rst = ($urandom_range(0, 99) != 0);
      bus.req_pipeline = N'($urandom);
      bus.active = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      bus.pipe_ready = ($urandom_range(0, 3) != 0);
      bus.reg_bank_req = ($urandom_range(0, 3) == 0) ? N'($urandom) : bus.reg_bank_req;
      bus.pipe_resp_valid = ($urandom_range(0, 2) != 0);
      rid = $urandom_range(0, N - 1);
      if ($urandom_range(0, 3) != 0) begin
        for (int j = 0; j < N; j++) begin
          if (m_out[(rid + j) % N]) begin
            rid = (rid + j) % N;
            break;
          end
        end
      end
      bus.pipe_resp_id = ID_W'(rid);
      bus.pipe_resp_ok = ($urandom_range(0, 1) != 0);
      cycle();
    end

    // Reset with two outstanding and a register owner, then a stale failing response.
    do_reset();
    bus.req_pipeline = 4'b0011;
    bus.pipe_ready = 1'b1;
    bus.reg_bank_req = 4'b0001;
    cycle();
    cycle();
    cycle();
    n_rst = 1'b0;
    cycle();
    check("rst_valid", 32'(bus.pipe_valid), 32'h0);
    check("rst_grant", 32'(bus.pipeline_granted), 32'h0);
    check("rst_rb", 32'(bus.reg_bank_granted), 32'h0);
    n_rst = 1'b1;
    idle_inputs();
    respond(0, 1'b0);
    check("stale_resp", 32'(bus.pipeline_failed), 32'h0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
